// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU: default width, opcode map and shifter modes.
package alu_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic [5:0] OP_ADD = 6'h0A;
  localparam logic [5:0] OP_SUB = 6'h0B;
  localparam logic [5:0] OP_LSR = 6'h0C;
  localparam logic [5:0] OP_LSL = 6'h0D;
  localparam logic [5:0] OP_RSR = 6'h0E;
  localparam logic [5:0] OP_RSL = 6'h0F;
  localparam logic [5:0] OP_MOV = 6'h10;
  localparam logic [5:0] OP_MUL = 6'h11;
  localparam logic [5:0] OP_DIV = 6'h12;
  localparam logic [5:0] OP_MOD = 6'h13;
  localparam logic [5:0] OP_AND = 6'h14;
  localparam logic [5:0] OP_OR  = 6'h15;
  localparam logic [5:0] OP_XOR = 6'h16;
  localparam logic [5:0] OP_NOT = 6'h17;
  localparam logic [5:0] OP_CMP = 6'h18;
  localparam logic [5:0] OP_TST = 6'h19;
  localparam logic [5:0] OP_INC = 6'h1A;
  localparam logic [5:0] OP_DEC = 6'h1B;

  typedef enum logic [1:0] {
    SH_LSR = 2'd0,
    SH_LSL = 2'd1,
    SH_RSR = 2'd2,
    SH_RSL = 2'd3
  } shift_mode_e;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode inputs and registered result/flag outputs of the ALU.
interface alu_if #(parameter int unsigned WIDTH = alu_pkg::WIDTH);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [5:0]       opcode;
  logic [WIDTH-1:0] out;
  logic             Z;
  logic             N;
  logic             C;
  logic             O;

  modport master (output A, B, opcode, input out, Z, N, C, O);
  modport slave  (input A, B, opcode, output out, Z, N, C, O);
endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel unit for logical shifts and rotates.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amount,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned RW = $clog2(WIDTH);

  logic [RW-1:0]      rot;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] dbl_r;
  logic [2*WIDTH-1:0] dbl_l;

  // Rotates use only the low amount bits; doubling A makes the wrap-around a plain shift.
  assign rot   = amount[RW-1:0];
  assign dbl   = {a, a};
  assign dbl_r = dbl >> rot;
  assign dbl_l = dbl << rot;

  always_comb begin
    result = '0;
    case (mode)
      SH_LSR:  result = a >> amount;
      SH_LSL:  result = a << amount;
      SH_RSR:  result = dbl_r[WIDTH-1:0];
      SH_RSL:  result = dbl_l[2*WIDTH-1:WIDTH];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Opcode-decoded integer ALU with a single registered result/flag bank.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [5:0]         op;
  logic [WIDTH-1:0]   b_arith;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic               add_ovf;
  logic               sub_ovf;
  logic               b_zero;
  shift_mode_e        sh_mode;
  logic [WIDTH-1:0]   sh_result;
  logic [WIDTH-1:0]   res;
  logic               c_flag;
  logic               o_flag;

  assign a  = bus.A;
  assign b  = bus.B;
  assign op = bus.opcode;

  // INC/DEC reuse the adder and subtractor with an implicit operand of one.
  assign b_arith = (op == OP_INC || op == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign sum     = {1'b0, a} + {1'b0, b_arith};
  assign diff    = {1'b0, a} - {1'b0, b_arith};
  assign prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign add_ovf = (a[MSB] == b_arith[MSB]) && (sum[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b_arith[MSB]) && (diff[MSB] != a[MSB]);
  assign b_zero  = (b == '0);

  always_comb begin
    sh_mode = SH_LSR;
    case (op)
      OP_LSL:  sh_mode = SH_LSL;
      OP_RSR:  sh_mode = SH_RSR;
      OP_RSL:  sh_mode = SH_RSL;
      default: sh_mode = SH_LSR;
    endcase
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a      (a),
    .amount (b),
    .mode   (sh_mode),
    .result (sh_result)
  );

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    o_flag = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        o_flag = add_ovf;
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        res    = diff[WIDTH-1:0];
        c_flag = ~diff[WIDTH];
        o_flag = sub_ovf;
      end
      OP_LSR, OP_LSL, OP_RSR, OP_RSL: res = sh_result;
      OP_MOV: res = b;
      OP_MUL: begin
        res    = prod[WIDTH-1:0];
        c_flag = (prod[2*WIDTH-1:WIDTH] != '0);
      end
      OP_DIV: begin
        res    = b_zero ? '1 : a / b;
        o_flag = b_zero;
      end
      OP_MOD: begin
        res    = b_zero ? a : a % b;
        o_flag = b_zero;
      end
      OP_AND, OP_TST: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out <= '0;
      bus.Z   <= 1'b0;
      bus.N   <= 1'b0;
      bus.C   <= 1'b0;
      bus.O   <= 1'b0;
    end else begin
      bus.out <= res;
      bus.Z   <= (res == '0);
      bus.N   <= res[MSB];
      bus.C   <= c_flag;
      bus.O   <= o_flag;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: each vector checks {out,Z,N,C,O} one edge after issue.
module tb_alu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_if #(.WIDTH(16)) bus ();

  alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got out=%h ZNCO=%b, expected out=%h ZNCO=%b",
               tag, got[19:4], got[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  // Apply one op, take one edge, compare registered result and flags (ZNCO order).
  task automatic run_op(input string tag, input logic [5:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_out,
                        input logic [3:0] exp_flags);
    bus.opcode = op;
    bus.A      = a;
    bus.B      = b;
    @(posedge clk);
    #1;
    check(tag, {bus.out, bus.Z, bus.N, bus.C, bus.O}, {exp_out, exp_flags});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n      = 1'b0;
    bus.opcode = OP_ADD;
    bus.A      = 16'hFFFF;
    bus.B      = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {bus.out, bus.Z, bus.N, bus.C, bus.O}, {16'h0000, 4'b0000});
    rst_n = 1'b1;

    run_op("add_wrap",  OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    // Inputs changed after the edge must not reach the outputs before the next edge.
    bus.opcode = OP_ADD;
    bus.A      = 16'h7FFF;
    bus.B      = 16'h0001;
    #2;
    check("latency_hold", {bus.out, bus.Z, bus.N, bus.C, bus.O}, {16'h0000, 4'b1010});
    @(posedge clk);
    #1;
    check("add_ovf", {bus.out, bus.Z, bus.N, bus.C, bus.O}, {16'h8000, 4'b0101});

    run_op("sub",       OP_SUB, 16'hFFFE, 16'h0001, 16'hFFFD, 4'b0110);
    run_op("sub_borrow",OP_SUB, 16'h0001, 16'h0002, 16'hFFFF, 4'b0100);
    run_op("sub_ovf",   OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
    run_op("lsr",       OP_LSR, 16'h000F, 16'h0004, 16'h0000, 4'b1000);
    run_op("lsr_0",     OP_LSR, 16'h1234, 16'h0000, 16'h1234, 4'b0000);
    run_op("lsr_16",    OP_LSR, 16'h8000, 16'h0010, 16'h0000, 4'b1000);
    run_op("lsl",       OP_LSL, 16'h3000, 16'h0002, 16'hC000, 4'b0100);
    run_op("lsl_16",    OP_LSL, 16'h0001, 16'h0010, 16'h0000, 4'b1000);
    run_op("lsl_0",     OP_LSL, 16'h0001, 16'h0000, 16'h0001, 4'b0000);
    run_op("rsr",       OP_RSR, 16'h000B, 16'h0002, 16'hC002, 4'b0100);
    run_op("rsr_16",    OP_RSR, 16'h1234, 16'h0010, 16'h1234, 4'b0000);
    run_op("rsl",       OP_RSL, 16'hB000, 16'h0002, 16'hC002, 4'b0100);
    run_op("rsl_0",     OP_RSL, 16'h1234, 16'h0000, 16'h1234, 4'b0000);
    run_op("mov",       OP_MOV, 16'h1234, 16'h4321, 16'h4321, 4'b0000);
    run_op("mul",       OP_MUL, 16'h0002, 16'h0004, 16'h0008, 4'b0000);
    run_op("mul_hi",    OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1010);
    run_op("div",       OP_DIV, 16'h000A, 16'h0002, 16'h0005, 4'b0000);
    run_op("div_0",     OP_DIV, 16'h1234, 16'h0000, 16'hFFFF, 4'b0101);
    run_op("mod",       OP_MOD, 16'h0009, 16'h0002, 16'h0001, 4'b0000);
    run_op("mod_0",     OP_MOD, 16'h1234, 16'h0000, 16'h1234, 4'b0001);
    run_op("and",       OP_AND, 16'hAAAA, 16'hAA22, 16'hAA22, 4'b0100);
    run_op("or",        OP_OR,  16'h8888, 16'h2222, 16'hAAAA, 4'b0100);
    run_op("xor",       OP_XOR, 16'hFFFF, 16'h8888, 16'h7777, 4'b0000);
    run_op("not",       OP_NOT, 16'hFF22, 16'h5A5A, 16'h00DD, 4'b0000);
    run_op("tst",       OP_TST, 16'hAAAA, 16'hAA22, 16'hAA22, 4'b0100);
    run_op("cmp",       OP_CMP, 16'hFFFE, 16'h0001, 16'hFFFD, 4'b0110);
    run_op("inc",       OP_INC, 16'h000F, 16'h7777, 16'h0010, 4'b0000);
    run_op("inc_wrap",  OP_INC, 16'hFFFF, 16'h0000, 16'h0000, 4'b1010);
    run_op("dec",       OP_DEC, 16'h000A, 16'h7777, 16'h0009, 4'b0010);
    run_op("dec_wrap",  OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 4'b0100);
    run_op("op_3f",     6'h3F,  16'h1234, 16'h5678, 16'h0000, 4'b1000);
    run_op("op_00",     6'h00,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000);

    run_op("pre_reset", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    rst_n = 1'b0;
    run_op("reset_prio", OP_ADD, 16'h7FFF, 16'h0001, 16'h0000, 4'b0000);
    rst_n = 1'b1;
    run_op("post_reset", OP_XOR, 16'hFFFF, 16'h8888, 16'h7777, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
